// File: rtl/arc4_crack_ctrl.sv
// ---------------------------------------------------------------------------
// arc4_crack_ctrl
//   Brute-force key-search controller.  Sweeps an inclusive key range
//   [key_lo, key_hi] across NCH arc4 decrypt channels in lock-step batches.
//   After each batch it samples the live channels' plaintext-valid flags.
//   It stops on the lowest-index hit, or when the range is exhausted.
//
//   Optional feature macro: ARC4_CRACK_PERF_EN
//     When defined, adds o_cycles, a saturating 32-bit count of cycles with
//     o_rdy=0.  The count is cleared on each accepted start.
//
// Ports
//   i_clk      system clock (rising edge)
//   i_rst_n    asynchronous active-low reset
//   i_en       start request, accepted only while o_rdy=1
//   o_rdy      controller idle / result valid
//   i_key_lo   first key of range (sampled on accepted i_en)
//   i_key_hi   last key of range, inclusive (sampled on accepted i_en)
//   o_ch_en    per-channel one-cycle start pulse
//   o_ch_key   channel i key at [i*KEY_W +: KEY_W], held until completion
//   i_ch_rdy   per-channel idle/done
//   i_ch_ok    per-channel plaintext valid (meaningful while i_ch_rdy=1)
//   o_found    last search hit
//   o_key      hit key (0 if no hit)
//   o_cycles   (ARC4_CRACK_PERF_EN only) busy-cycle count
// ---------------------------------------------------------------------------

// Per-channel key generation: key = base + LANE.
// The channel is live when that key is still inside the range.  The compare
// uses one extra bit, so a batch near the top of the key space cannot wrap
// back to 0.
module arc4_crack_lane #(
    parameter int KEY_W = 24,
    parameter int LANE  = 0
) (
    input  logic [KEY_W-1:0] i_base,
    input  logic [KEY_W-1:0] i_hi,
    output logic [KEY_W-1:0] o_key,
    output logic             o_live
);
    logic [KEY_W:0] w_sum;

    assign w_sum  = {1'b0, i_base} + (KEY_W+1)'(LANE);
    assign o_key  = w_sum[KEY_W-1:0];
    assign o_live = (w_sum <= {1'b0, i_hi});
endmodule

module arc4_crack_ctrl #(
    parameter int KEY_W = 24,
    parameter int NCH   = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    output logic                 o_rdy,
    input  logic [KEY_W-1:0]     i_key_lo,
    input  logic [KEY_W-1:0]     i_key_hi,
    output logic [NCH-1:0]       o_ch_en,
    output logic [NCH*KEY_W-1:0] o_ch_key,
    input  logic [NCH-1:0]       i_ch_rdy,
    input  logic [NCH-1:0]       i_ch_ok,
    output logic                 o_found,
    output logic [KEY_W-1:0]     o_key
`ifdef ARC4_CRACK_PERF_EN
    ,
    output logic [31:0]          o_cycles
`endif
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_GAP,
        S_WAIT,
        S_CHECK
    } state_t;

    typedef struct packed {
        logic [KEY_W-1:0] base;
        logic [KEY_W-1:0] hi;
    } range_t;

    state_t                      r_state, w_state_d;
    range_t                      r_rng, w_rng_d;
    logic [NCH-1:0][KEY_W-1:0]   r_ch_key;
    logic [NCH-1:0]              r_live;
    logic                        r_found;
    logic [KEY_W-1:0]            r_key;

    logic [NCH-1:0][KEY_W-1:0]   w_lane_key;
    logic [NCH-1:0]              w_lane_live;
    logic [NCH-1:0]              w_hits;
    logic [KEY_W-1:0]            w_hit_key;
    logic                        w_last;
    logic                        w_load;
    logic                        w_accept;
    logic                        w_done_hit;
    logic                        w_done_miss;

    // The lanes look at the *next* base.  This lets channel keys and the
    // live mask be registered on the edge that enters LAUNCH.  They are then
    // already valid during the start pulse.
    for (genvar g = 0; g < NCH; g++) begin : g_lane
        arc4_crack_lane #(
            .KEY_W (KEY_W),
            .LANE  (g)
        ) u_lane (
            .i_base (w_rng_d.base),
            .i_hi   (w_rng_d.hi),
            .o_key  (w_lane_key[g]),
            .o_live (w_lane_live[g])
        );
    end

    assign w_hits = i_ch_ok & r_live;
    assign w_last = ({1'b0, r_rng.base} + (KEY_W+1)'(NCH)) > {1'b0, r_rng.hi};

    // Lowest-index hit wins: scan from the top so that lower lanes overwrite.
    always_comb begin
        w_hit_key = '0;
        for (int i = NCH-1; i >= 0; i--) begin
            if (w_hits[i]) w_hit_key = r_ch_key[i];
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_rng_d     = r_rng;
        w_load      = 1'b0;
        w_accept    = 1'b0;
        w_done_hit  = 1'b0;
        w_done_miss = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_en) begin
                    w_accept     = 1'b1;
                    w_rng_d.base = i_key_lo;
                    w_rng_d.hi   = i_key_hi;
                    if (i_key_lo <= i_key_hi) begin
                        w_load    = 1'b1;
                        w_state_d = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: w_state_d = S_GAP;
            // Channels drop rdy only the cycle after their start pulse.
            S_GAP:    w_state_d = S_WAIT;
            S_WAIT: begin
                if ((i_ch_rdy & r_live) == r_live) w_state_d = S_CHECK;
            end
            S_CHECK: begin
                if (|w_hits) begin
                    w_done_hit = 1'b1;
                    w_state_d  = S_IDLE;
                end else if (w_last) begin
                    w_done_miss = 1'b1;
                    w_state_d   = S_IDLE;
                end else begin
                    w_rng_d.base = r_rng.base + KEY_W'(NCH);
                    w_load       = 1'b1;
                    w_state_d    = S_LAUNCH;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_rng    <= '0;
            r_ch_key <= '0;
            r_live   <= '0;
            r_found  <= 1'b0;
            r_key    <= '0;
        end else begin
            r_state <= w_state_d;
            r_rng   <= w_rng_d;
            if (w_load) begin
                r_ch_key <= w_lane_key;
                r_live   <= w_lane_live;
            end
            if (w_accept || w_done_miss) begin
                r_found <= 1'b0;
                r_key   <= '0;
            end else if (w_done_hit) begin
                r_found <= 1'b1;
                r_key   <= w_hit_key;
            end
        end
    end

    // The start pulse is decoded from the state register.  It therefore
    // falls as soon as reset asserts.
    assign o_ch_en  = (r_state == S_LAUNCH) ? r_live : '0;
    assign o_ch_key = r_ch_key;
    assign o_rdy    = (r_state == S_IDLE);
    assign o_found  = r_found;
    assign o_key    = r_key;

`ifdef ARC4_CRACK_PERF_EN
    logic [31:0] r_cycles;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cycles <= '0;
        end else if (w_accept) begin
            r_cycles <= '0;
        end else if (r_state != S_IDLE && r_cycles != 32'hFFFF_FFFF) begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    assign o_cycles = r_cycles;
`endif
endmodule

// File: tb/tb_arc4_crack_ctrl.sv
module tb_arc4_crack_ctrl;
    localparam int KW = 24;
    localparam int NC = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic           rdy;
    logic [KW-1:0]  key_lo = '0;
    logic [KW-1:0]  key_hi = '0;
    logic [NC-1:0]  ch_en;
    logic [NC*KW-1:0] ch_key;
    logic [NC-1:0]  ch_rdy = '1;
    logic [NC-1:0]  ch_ok = '0;
    logic           found;
    logic [KW-1:0]  key;
`ifdef ARC4_CRACK_PERF_EN
    logic [31:0]    cycles;
`endif

    int n_assert = 0;
    int n_fail = 0;

    arc4_crack_ctrl #(.KEY_W(KW), .NCH(NC)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_en     (en),
        .o_rdy    (rdy),
        .i_key_lo (key_lo),
        .i_key_hi (key_hi),
        .o_ch_en  (ch_en),
        .o_ch_key (ch_key),
        .i_ch_rdy (ch_rdy),
        .i_ch_ok  (ch_ok),
        .o_found  (found),
        .o_key    (key)
`ifdef ARC4_CRACK_PERF_EN
        ,
        .o_cycles (cycles)
`endif
    );

    always #5 clk = ~clk;

    // Channel model: rdy high again 5 cycles after the start pulse.
    // ok is raised only when the latched key equals that channel's good key.
    logic [KW-1:0] good [NC];
    logic [KW-1:0] m_key [NC];
    int            m_cnt [NC];

    always @(posedge clk) begin
        for (int i = 0; i < NC; i++) begin
            if (ch_en[i] && ch_rdy[i]) begin
                ch_rdy[i] <= 1'b0;
                ch_ok[i]  <= 1'b0;
                m_cnt[i]  <= 3;
                m_key[i]  <= ch_key[i*KW +: KW];
            end else if (!ch_rdy[i]) begin
                if (m_cnt[i] == 0) begin
                    ch_rdy[i] <= 1'b1;
                    ch_ok[i]  <= (m_key[i] == good[i]);
                end else begin
                    m_cnt[i] <= m_cnt[i] - 1;
                end
            end
        end
    end

    // Monitors: these counters only ever increase, and the stimulus works on
    // differences of their values.
    int low_cnt = 0;
    int pulses [NC] = '{0, 0};
    int over_cnt = 0;
    int viol_cnt = 0;
    logic [KW-1:0] limit = '1;

    always @(negedge clk) if (!rdy) low_cnt++;

    always @(posedge clk) begin
        for (int i = 0; i < NC; i++) begin
            if (ch_en[i]) begin
                pulses[i]++;
                if (ch_key[i*KW +: KW] > limit) over_cnt++;
                if (!ch_rdy[i]) viol_cnt++;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int s_low, s_p0, s_p1, s_over;

    task automatic snap();
        s_low  = low_cnt;
        s_p0   = pulses[0];
        s_p1   = pulses[1];
        s_over = over_cnt;
    endtask

    task automatic wait_rdy(input string tag);
        int n = 0;
        while (!rdy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(rdy), 64'd1);
    endtask

    task automatic run(input logic [KW-1:0] lo, input logic [KW-1:0] hi, input int hold);
        @(negedge clk);
        snap();
        key_lo = lo;
        key_hi = hi;
        en     = 1'b1;
        repeat (hold) @(negedge clk);
        en = 1'b0;
        wait_rdy("search_timeout");
    endtask

    initial begin
        good[0] = '1;
        good[1] = '1;
        #1;
        chk("rst_rdy",    64'(rdy),    64'd1);
        chk("rst_found",  64'(found),  64'd0);
        chk("rst_key",    64'(key),    64'd0);
        chk("rst_ch_en",  64'(ch_en),  64'd0);
        chk("rst_ch_key", 64'(ch_key), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Hit in channel 1 at key 0x13: 10 batches of 7 cycles each.
        good[0] = 24'h000013;
        good[1] = 24'h000013;
        limit   = 24'h000013;
        run(24'h000000, 24'h0000FF, 1);
        chk("hit_found", 64'(found), 64'd1);
        chk("hit_key",   64'(key),   64'h13);
        chk("hit_busy",  64'(low_cnt - s_low), 64'd70);
        chk("hit_over",  64'(over_cnt - s_over), 64'd0);
        chk("hit_p0",    64'(pulses[0] - s_p0), 64'd10);
        chk("hit_p1",    64'(pulses[1] - s_p1), 64'd10);
`ifdef ARC4_CRACK_PERF_EN
        chk("hit_cycles", 64'(cycles), 64'd70);
`endif
        limit = '1;

        // Tie at base 0x20: both channels report ok, so lane 0 wins.
        good[0] = 24'h000020;
        good[1] = 24'h000021;
        run(24'h000000, 24'h0000FF, 1);
        chk("tie_found", 64'(found), 64'd1);
        chk("tie_key",   64'(key),   64'h20);
        chk("tie_busy",  64'(low_cnt - s_low), 64'd119);

        // Empty range: the start is accepted and clears the last result,
        // but no channel is started.
        run(24'h000005, 24'h000004, 1);
        chk("empty_found", 64'(found), 64'd0);
        chk("empty_key",   64'(key),   64'd0);
        chk("empty_busy",  64'(low_cnt - s_low), 64'd0);
        chk("empty_p",     64'((pulses[0] - s_p0) + (pulses[1] - s_p1)), 64'd0);

        // Odd range 0..4, no hit: batches 0, 2 and 4.  The last batch starts
        // lane 0 only.
        good[0] = '1;
        good[1] = '1;
        run(24'h000000, 24'h000004, 1);
        chk("odd_found", 64'(found), 64'd0);
        chk("odd_key",   64'(key),   64'd0);
        chk("odd_busy",  64'(low_cnt - s_low), 64'd21);
        chk("odd_p0",    64'(pulses[0] - s_p0), 64'd3);
        chk("odd_p1",    64'(pulses[1] - s_p1), 64'd2);

        // Top of key space: one batch, with no wrap back to key 0.
        good[0] = 24'h000000;
        good[1] = 24'h000000;
        run(24'hFFFFFE, 24'hFFFFFF, 1);
        chk("top_found", 64'(found), 64'd0);
        chk("top_busy",  64'(low_cnt - s_low), 64'd7);
        chk("top_p",     64'((pulses[0] - s_p0) + (pulses[1] - s_p1)), 64'd2);

        // en held high for 10 cycles of a 14-cycle search.  The extra
        // requests must be ignored.
        good[0] = 24'h000003;
        good[1] = 24'h000003;
        run(24'h000000, 24'h000009, 10);
        chk("hold_found", 64'(found), 64'd1);
        chk("hold_key",   64'(key),   64'h3);
        chk("hold_busy",  64'(low_cnt - s_low), 64'd14);
`ifdef ARC4_CRACK_PERF_EN
        chk("hold_cycles", 64'(cycles), 64'd14);
`endif

        // Reset while the controller waits for the channels.
        good[0] = '1;
        good[1] = '1;
        @(negedge clk);
        key_lo = 24'h000000;
        key_hi = 24'h0000FF;
        en     = 1'b1;
        @(negedge clk);
        en = 1'b0;
        chk("launch_ch_en", 64'(ch_en), 64'd3);
        chk("launch_rdy",   64'(rdy),   64'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rdy",    64'(rdy),    64'd1);
        chk("mid_rst_found",  64'(found),  64'd0);
        chk("mid_rst_key",    64'(key),    64'd0);
        chk("mid_rst_ch_en",  64'(ch_en),  64'd0);
        chk("mid_rst_ch_key", 64'(ch_key), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // The first search after reset must start cleanly.
        good[0] = 24'h000001;
        good[1] = 24'h000001;
        run(24'h000000, 24'h000003, 1);
        chk("post_found", 64'(found), 64'd1);
        chk("post_key",   64'(key),   64'h1);
        chk("post_busy",  64'(low_cnt - s_low), 64'd7);

        chk("no_en_while_busy", 64'(viol_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/arc4_crack_ctrl.md
# arc4_crack_ctrl

Parametrised brute-force key-search controller for the ARC4 datapath. It sweeps an inclusive key range across `NCH` parallel `arc4` decrypt channels in lock-step, using the same `en`/`rdy` handshake as the `arc4` core. After each batch it samples every channel's plaintext-valid flag and stops on the first hit or when the range is exhausted. It sits between the board top level (switches/keys/HEX) and the channel array, replacing the single-key, single-core run controller.

## Interface
Parameters:
- `KEY_W`, 24: key width in bits.
- `NCH`, 2: number of parallel arc4 channels (1..16).

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  start request; accepted only while `rdy`=1.
- `rdy`  out  1  controller idle, result valid.
- `key_lo`  in  KEY_W  first key of range; sampled when `en` is accepted.
- `key_hi`  in  KEY_W  last key of range (inclusive); sampled when `en` is accepted.
- `ch_en`  out  NCH  one-cycle start pulse per channel.
- `ch_key`  out  NCH*KEY_W  key for channel i at bits [i*KEY_W +: KEY_W]; stable from pulse to completion.
- `ch_rdy`  in  NCH  channel idle/done (arc4 `rdy`).
- `ch_ok`  in  NCH  channel plaintext valid; meaningful only while that channel's `ch_rdy`=1 after completion.
- `found`  out  1  last search hit.
- `key`  out  KEY_W  hit key (0 if no hit).

## Operation
- States: IDLE, LAUNCH, GAP, WAIT, CHECK.
- Reset values (async): state=IDLE, `rdy`=1, `found`=0, `key`=0, `ch_en`=0, `ch_key`=0, base=0.
- IDLE:
  - `rdy`=1.
  - On `en`=1: latch base←`key_lo`, hi←`key_hi`, clear `found`/`key`.
  - If `key_lo`>`key_hi`: remain IDLE; `found`=0, `rdy` stays 1.
  - Otherwise → LAUNCH.
- LAUNCH:
  - Channel i is live iff base+i ≤ hi. Compare at KEY_W+1 bits; no wrap at 2^KEY_W−1.
  - Set `ch_key[i]`=base+i for every channel; pulse `ch_en[i]`=1 for live channels only.
  - Latch the live mask → GAP.
- GAP: one cycle, `ch_rdy` ignored (channels drop `rdy` the cycle after `en`) → WAIT.
- WAIT: stay until `ch_rdy` & live == live; non-live channels are ignored → CHECK.
- CHECK:
  - hits = `ch_ok` & live.
  - Any hit: `found`←1, `key`←base+j, where j is the lowest-index hit → IDLE.
  - Else, if base+NCH > hi (KEY_W+1-bit compare): `found`←0, `key`←0 → IDLE.
  - Else: base←base+NCH → LAUNCH.
- `en` while `rdy`=0 is ignored.
- `found`/`key` hold until the next accepted `en`.
- Reset mid-search: immediate return to reset values; `ch_en` drops asynchronously; channels are not otherwise aborted.

## Timing
- `en` accepted at edge k: `rdy`=0 from k+1; `ch_en` high during cycle k+1 only.
- Per batch: LAUNCH(1) + GAP(1) + WAIT(≥1) + CHECK(1) cycles.
- With channel latency L cycles from `en` to `rdy` re-high (L≥2), each batch takes L+2 cycles.
- `rdy`=1, `found` and `key` all update on the same edge leaving CHECK.
- Batches per search = ceil((hi−lo+1)/NCH).
- `ch_en` is never asserted to a channel whose `ch_rdy`=0.

## Configuration
- `ARC4_CRACK_PERF_EN` defined:
  - Adds output `cycles` (32-bit), reset 0.
  - Cleared on accepted `en`; increments every cycle `rdy`=0; holds in IDLE; saturates at 2^32−1.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset: assert `rst_n`=0 mid-WAIT -> `rdy`=1, `found`=0, `key`=0, `ch_en`=0 immediately; post-reset `en` starts a clean search.
- Bench setup for the remaining scenarios: `NCH`=2, `KEY_W`=24, model channels with L=5 that raise `ch_ok` only for a chosen key.
- Hit in channel 1: range 0x000000..0x0000FF, good key 0x000013 -> `found`=1, `key`=0x000013 after 10 batches (70 cycles); `ch_en` never pulsed for keys >0x13.
- Tie: both channels report ok in batch base=0x20 -> `key`=0x000020 (lowest index wins).
- Odd range, no hit: 0x000000..0x000004 -> batches 0,2,4; last batch pulses `ch_en[0]` only; `found`=0, `key`=0.
- Top-of-space: range 0xFFFFFE..0xFFFFFF, no hit -> single batch, no wrap to 0; `rdy` returns after 7 cycles. Empty range `key_lo`=5, `key_hi`=4 -> no `ch_en`, `rdy` never drops.
- Handshake: `en` held high during a search -> ignored until `rdy`=1; with `ARC4_CRACK_PERF_EN`, `cycles` equals the `rdy`-low count (70 in the channel-1 hit case).
